// File: rtl/target_net_sync_ctrl.sv
// Target-network sync sequencer: periodically copies one layer's
// weight vectors and biases from the policy net into target memory.
module target_net_sync_ctrl #(
   parameter int DATA_WIDTH         = 32,
   parameter int MEM_WIDTH          = 5,
   parameter int NODE_WIDTH_PREV    = 2,
   parameter int NODE_WIDTH_CURRENT = 32,
   parameter int SYNC_PERIOD        = 100,
   parameter int CNT_WIDTH          = 16,
   parameter int TIMEOUT            = 255
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  i_train_step,
   input  logic                                  i_force_sync,
   output logic                                  o_src_req,
   output logic [MEM_WIDTH-1:0]                  o_src_addr,
   input  logic                                  i_src_valid,
   input  logic [DATA_WIDTH*NODE_WIDTH_PREV-1:0] i_src_weight,
   input  logic [DATA_WIDTH-1:0]                 i_src_bias,
   output logic                                  o_mem_enable,
   output logic                                  o_rw_mem,
   output logic                                  o_update_weight,
   output logic [MEM_WIDTH-1:0]                  o_addr,
   output logic [DATA_WIDTH*NODE_WIDTH_PREV-1:0] o_weight,
   output logic [DATA_WIDTH-1:0]                 o_bias,
   output logic                                  o_busy,
   output logic                                  o_done,
   output logic                                  o_error
);

   localparam int WW = DATA_WIDTH * NODE_WIDTH_PREV;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [MEM_WIDTH-1:0] LAST_ADDR =
      MEM_WIDTH'(NODE_WIDTH_CURRENT - 1);
   localparam logic [CNT_WIDTH-1:0] TERM_CNT =
      CNT_WIDTH'(SYNC_PERIOD - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [MEM_WIDTH-1:0]  addr_q, addr_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic                  pend_q, pend_d;
   logic [WW-1:0]         weight_q, weight_d;
   logic [DATA_WIDTH-1:0] bias_q, bias_d;
   logic                  term;

   always_comb begin
      cnt_d = cnt_q;
      term  = 1'b0;
      if (i_train_step) begin
         if (cnt_q == TERM_CNT) begin
            cnt_d = '0;
            term  = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      tmo_d           = tmo_q;
      pend_d          = pend_q;
      weight_d        = weight_q;
      bias_d          = bias_q;
      o_src_req       = 1'b0;
      o_src_addr      = '0;
      o_mem_enable    = 1'b0;
      o_rw_mem        = 1'b1;
      o_update_weight = 1'b0;
      o_addr          = '0;
      o_done          = 1'b0;
      o_error         = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (pend_q) begin
               pend_d  = 1'b0;
               addr_d  = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            o_src_req  = 1'b1;
            o_src_addr = addr_q;
            tmo_d      = '0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (i_src_valid) begin
               weight_d = i_src_weight;
               bias_d   = i_src_bias;
               state_d  = S_WRITE;
            end else if (tmo_q == TMO_LAST) begin
               // abort leaves earlier nodes written; no rollback
               o_error = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_WRITE: begin
            o_mem_enable    = 1'b1;
            o_rw_mem        = 1'b0;
            o_update_weight = 1'b1;
            o_addr          = addr_q;
            if (addr_q == LAST_ADDR) begin
               state_d = S_DONE;
            end else begin
               addr_d  = addr_q + MEM_WIDTH'(1);
               state_d = S_REQ;
            end
         end
         S_DONE: begin
            o_done  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // a request arriving mid-sync queues one follow-up sync
      if (term || i_force_sync) begin
         pend_d = 1'b1;
      end
   end

   assign o_busy   = (state_q != S_IDLE);
   assign o_weight = weight_q;
   assign o_bias   = bias_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         tmo_q    <= '0;
         pend_q   <= 1'b0;
         weight_q <= '0;
         bias_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         tmo_q    <= tmo_d;
         pend_q   <= pend_d;
         weight_q <= weight_d;
         bias_q   <= bias_d;
      end
   end

endmodule

// File: doc/target_net_sync_ctrl.md
Name: target_net_sync_ctrl

Overview:
- Periodic weight-copy sequencer for the DQN target network; sits directly upstream of the target-net per-layer memory and drives its write port.
- Counts training steps. Every SYNC_PERIOD steps, or on a force request, it walks every node address of one layer.
- For each node it fetches weight vector and bias from the main (policy) network over a request/valid handshake, then writes them into target memory with update-weight asserted.
- One instance per layer (hidden 1, hidden 2, output).

Parameters:
- DATA_WIDTH, 32, width of one fixed/float word
- MEM_WIDTH, 5, address width of target memory
- NODE_WIDTH_PREV, 2, fan-in of current layer; weight bus carries DATA_WIDTH*NODE_WIDTH_PREV bits
- NODE_WIDTH_CURRENT, 32, number of nodes (addresses 0..NODE_WIDTH_CURRENT-1) to copy
- SYNC_PERIOD, 100, training steps between automatic syncs (>=1)
- CNT_WIDTH, 16, width of step counter (must hold SYNC_PERIOD-1)
- TIMEOUT, 255, max cycles waiting for source valid before abort (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_train_step  in  1  one-cycle pulse per completed training step
- i_force_sync  in  1  pulse: request immediate sync
- o_src_req  out  1  one-cycle read request to main-net memory
- o_src_addr  out  MEM_WIDTH  node address of request
- i_src_valid  in  1  source data valid
- i_src_weight  in  DATA_WIDTH*NODE_WIDTH_PREV  main-net weight vector
- i_src_bias  in  DATA_WIDTH  main-net bias
- o_mem_enable  out  1  target memory enable
- o_rw_mem  out  1  1 read / 0 write to target memory
- o_update_weight  out  1  1 = write weight+bias
- o_addr  out  MEM_WIDTH  target memory address
- o_weight  out  DATA_WIDTH*NODE_WIDTH_PREV  weight to target memory
- o_bias  out  DATA_WIDTH  bias to target memory
- o_busy  out  1  high from leaving IDLE until returning to IDLE
- o_done  out  1  one-cycle pulse: full layer copied
- o_error  out  1  one-cycle pulse: source timeout, sync aborted

Behaviour:
- Reset: all outputs 0, except o_rw_mem=1 (read, safe). FSM=IDLE. Step counter, node address, timeout counter and pending flag all 0.
- Step counter: on i_train_step, if count==SYNC_PERIOD-1 then count<=0 and pending<=1; else count+1. Counts in every state, never stalls.
- i_force_sync sets pending in any state.
- Pending: cleared when IDLE->REQ is taken. If pending is set during a sync, a new sync starts right after the current one ends. Multiple requests collapse to one.
- FSM states: IDLE, REQ, WAIT, WRITE, DONE.
- IDLE: when pending=1, addr<=0 and go to REQ.
- REQ (1 cycle): o_src_req=1, o_src_addr=addr; timeout counter<=0; go to WAIT.
- WAIT: i_src_valid is sampled only in WAIT (valid in the REQ cycle is ignored).
  - On valid: latch i_src_weight into o_weight and i_src_bias into o_bias; go to WRITE.
  - Otherwise timeout counter+1. On reaching TIMEOUT: pulse o_error, go to IDLE with pending unchanged. Target memory stays partially updated, with no rollback.
- WRITE (1 cycle): o_mem_enable=1, o_rw_mem=0, o_update_weight=1, o_addr=addr. o_weight/o_bias stay stable through this cycle.
  - If addr==NODE_WIDTH_CURRENT-1, go to DONE.
  - Else addr+1 and go to REQ.
- DONE (1 cycle): o_done=1; go to IDLE.
- Outside WRITE: o_mem_enable=0, o_rw_mem=1, o_update_weight=0. This block never issues reads to target memory.
- Latency: minimum 3 cycles per node (REQ, WAIT with valid, WRITE). A full layer takes at least 3*NODE_WIDTH_CURRENT+1 cycles from leaving IDLE to the DONE pulse.
- o_busy=1 in REQ, WAIT, WRITE and DONE.
- Address never exceeds NODE_WIDTH_CURRENT-1; no wrap inside one sync.
- Simultaneous i_train_step at terminal count and i_force_sync: one pending, one sync.
- Reset mid-sync: returns immediately to reset state. Pending is lost; the next sync needs a new trigger.

Test Plan:
- SYNC_PERIOD=4, NODE_WIDTH_CURRENT=3, zero-latency source (valid the cycle after req): 4 step pulses -> o_busy rises next cycle; o_src_addr 0,1,2; three WRITE cycles with o_addr 0,1,2 and weight/bias matching source; o_done pulse 10 cycles after leaving IDLE.
- 3 step pulses only -> no o_src_req, o_busy stays 0; the 4th pulse starts a sync and the counter reads 0 afterwards.
- i_force_sync during an active sync, plus a terminal step in the same cycle -> exactly one extra sync immediately after o_done, none further.
- Source delays valid 5 cycles at node 1 -> WAIT held 5 cycles; o_mem_enable never asserted early; o_weight at WRITE equals delayed source data.
- TIMEOUT=8, source never responds at node 2 -> o_error pulse 8 cycles after the node-2 req; FSM back in IDLE; nodes 0,1 written; no o_done.
- Assert rst_n low during WAIT of node 1 -> all outputs reset asynchronously; no further requests until a new trigger.
